// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider: operands and start in, status and results out.
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             err;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, err
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, err
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock.
// Optional `DIV_ZERO_ERR_EN: a zero divisor skips the iterations and raises err.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef DIV_ZERO_ERR_EN
    logic             err_q, err_d;
`endif

    // Trial value needs one extra bit: the shifted remainder can reach 2*divisor-1.
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        fits  = (trial >= {1'b0, div_q});
        diff  = trial[WIDTH-1:0] - div_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV_ZERO_ERR_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    div_d = bus.divisor;
                    quo_d = bus.dividend;
                    rem_d = '0;
                    cnt_d = CNT_W'(WIDTH - 1);
`ifdef DIV_ZERO_ERR_EN
                    if (bus.divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        err_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                // Dividend bits shift out of quo_q as quotient bits shift in.
                rem_d = fits ? diff : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], fits};
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
`ifdef DIV_ZERO_ERR_EN
                    err_d       = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

`ifdef DIV_ZERO_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: cycle-level arithmetic model plus directed,
// exhaustive and randomized stimulus.
module tb_seq_divider;
    localparam int W   = 4;
    localparam int LAT = W + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   cmp_en   = 1'b0;

    seq_divider_if #(.WIDTH(W)) dif ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input logic [W-1:0] d);
`ifdef DIV_ZERO_ERR_EN
        return (d == '0) ? 1 : LAT;
`else
        return LAT;
`endif
    endfunction

    function automatic logic [W-1:0] q_of(input logic [W-1:0] a, input logic [W-1:0] d);
        if (d == '0) return '1;
        return a / d;
    endfunction

    function automatic logic [W-1:0] r_of(input logic [W-1:0] a, input logic [W-1:0] d);
        if (d == '0) return a;
        return a % d;
    endfunction

    function automatic logic err_of(input logic [W-1:0] d);
`ifdef DIV_ZERO_ERR_EN
        return (d == '0);
`else
        return 1'b0;
`endif
    endfunction

    // Model: an accepted request completes lat_of() cycles later; results show in the done cycle.
    bit           m_pend    = 1'b0;
    int           m_done_at = 0;
    logic [W-1:0] m_q = '0, m_r = '0, held_q = '0, held_r = '0;
    logic         m_err = 1'b0, held_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend   <= 1'b0;
            held_q   <= '0;
            held_r   <= '0;
            held_err <= 1'b0;
        end else if (m_pend && cyc == m_done_at) begin
            m_pend   <= 1'b0;
            held_q   <= m_q;
            held_r   <= m_r;
            held_err <= m_err;
        end else if (!m_pend && dif.start) begin
            m_pend    <= 1'b1;
            m_done_at <= cyc + lat_of(dif.divisor);
            m_q       <= q_of(dif.dividend, dif.divisor);
            m_r       <= r_of(dif.dividend, dif.divisor);
            m_err     <= err_of(dif.divisor);
        end
    end

    logic         exp_busy, exp_done, exp_err;
    logic [W-1:0] exp_q, exp_r;
    assign exp_busy = m_pend;
    assign exp_done = m_pend && (cyc == m_done_at);
    assign exp_q    = exp_done ? m_q   : held_q;
    assign exp_r    = exp_done ? m_r   : held_r;
    assign exp_err  = exp_done ? m_err : held_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    endtask

    task automatic compare_loop();
        logic [2*W+2:0] act_v, exp_v;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                act_v = {dif.busy, dif.done, dif.err, dif.quotient, dif.remainder};
                exp_v = {exp_busy, exp_done, exp_err, exp_q, exp_r};
                n_checks++;
                if (act_v === exp_v) n_pass++;
                else $display("FAIL cycle_%0d busy/done/err/q/r: got %b/%b/%b/%0d/%0d, required %b/%b/%b/%0d/%0d",
                              cyc, dif.busy, dif.done, dif.err, dif.quotient, dif.remainder,
                              exp_busy, exp_done, exp_err, exp_q, exp_r);
                if (dif.done === 1'b1)
                    $display("txn cyc=%0d q=%0d r=%0d err=%0d", cyc, dif.quotient, dif.remainder, dif.err);
            end
        end
    endtask

    task automatic wait_done(output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (dif.done === 1'b1) begin
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] d, input bit lit,
                          input int elat, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ee, input string tag);
        int n0, at;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = a; dif.divisor = d;
        n0 = cyc;
        @(negedge clk);
        dif.start = 1'b0; dif.dividend = W'($urandom); dif.divisor = W'($urandom);
        if (lit) chk({tag, "_busy"}, 32'(dif.busy), 32'd1);
        wait_done(at);
        chk({tag, "_lat"}, (at < 0) ? -1 : at - n0, elat);
        if (lit) begin
            chk({tag, "_q"},   32'(dif.quotient),  32'(eq));
            chk({tag, "_r"},   32'(dif.remainder), 32'(er));
            chk({tag, "_err"}, 32'(dif.err),       32'(ee));
        end else begin
            chk({tag, "_qd_r"}, int'(dif.quotient) * int'(d) + int'(dif.remainder), int'(a));
            chk({tag, "_r_lt_d"}, 32'(dif.remainder < d), 32'd1);
        end
    endtask

    initial begin
        int n0, n1, at, dones, dc;
        dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
        fork compare_loop(); join_none
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        #1;
        chk("rst_busy", 32'(dif.busy), 32'd0);
        chk("rst_done", 32'(dif.done), 32'd0);
        chk("rst_err",  32'(dif.err),  32'd0);
        chk("rst_q",    32'(dif.quotient),  32'd0);
        chk("rst_r",    32'(dif.remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd13, 4'd3,  1'b1, 5, 4'd4,  4'd1, 1'b0, "d13_3");
        run_op(4'd15, 4'd1,  1'b1, 5, 4'd15, 4'd0, 1'b0, "d15_1");
        run_op(4'd7,  4'd9,  1'b1, 5, 4'd0,  4'd7, 1'b0, "d7_9");
        run_op(4'd15, 4'd15, 1'b1, 5, 4'd1,  4'd0, 1'b0, "d15_15");

        // start held high through 6/4, then switched to 10/3 while still high
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 4'd6; dif.divisor = 4'd4;
        n0 = cyc; dones = 0; dc = -1;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            if (dif.done === 1'b1) begin
                dones++; dc = cyc;
                chk("hold_q", 32'(dif.quotient),  32'd1);
                chk("hold_r", 32'(dif.remainder), 32'd2);
            end
        end
        chk("hold_one_done", dones, 1);
        chk("hold_lat", dc - n0, 5);
        dif.dividend = 4'd10; dif.divisor = 4'd3;
        @(negedge clk);
        chk("hold_gap_idle", 32'(dif.busy), 32'd0);
        n1 = cyc;
        @(negedge clk);
        dif.start = 1'b0;
        chk("b2b_busy", 32'(dif.busy), 32'd1);
        chk("b2b_prev_q_held", 32'(dif.quotient), 32'd1);
        wait_done(at);
        chk("b2b_lat", (at < 0) ? -1 : at - n1, 5);
        chk("b2b_q", 32'(dif.quotient),  32'd3);
        chk("b2b_r", 32'(dif.remainder), 32'd1);

        // reset during the second RUN cycle of 13/3
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 4'd13; dif.divisor = 4'd3;
        @(negedge clk);
        dif.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_q",    32'(dif.quotient),  32'd0);
        chk("abort_r",    32'(dif.remainder), 32'd0);
        chk("abort_busy", 32'(dif.busy),      32'd0);
        chk("abort_done", 32'(dif.done),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (dif.done === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 0);
        run_op(4'd9, 4'd2, 1'b1, 5, 4'd4, 4'd1, 1'b0, "d9_2");

`ifdef DIV_ZERO_ERR_EN
        run_op(4'd9, 4'd0, 1'b1, 1, 4'd15, 4'd9, 1'b1, "d9_0");
`else
        run_op(4'd9, 4'd0, 1'b1, 5, 4'd15, 4'd9, 1'b0, "d9_0");
`endif
        run_op(4'd8, 4'd2, 1'b1, 5, 4'd4, 4'd0, 1'b0, "d8_2");

        for (int a = 0; a < 16; a++) begin
            for (int d = 1; d < 16; d++) begin
                run_op(W'(a), W'(d), 1'b0, LAT, '0, '0, 1'b0, $sformatf("sw%0d_%0d", a, d));
            end
        end

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            dif.start    = ($urandom_range(0, 2) == 0);
            dif.dividend = W'($urandom);
            dif.divisor  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
        end
        @(negedge clk);
        dif.start = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
